// File: rtl/z_buffer_mem_responder.sv
// Depth-buffer memory responder: single-beat reads/writes over valid/ready
// handshakes with programmable response latency, plus a self-clear engine that
// fills every word with maximum depth (all ones).
module z_buffer_mem_responder #(
  parameter int                   Z_SIZE        = 8,
  parameter int                   X_RES         = 4,
  parameter int                   Y_RES         = 4,
  parameter int                   DEPTH         = X_RES * Y_RES,
  parameter int                   ADDR_SIZE     = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR     = '0,
  parameter int                   READ_LATENCY  = 1,
  parameter int                   WRITE_LATENCY = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 buf_r_w_i,
  input  logic [ADDR_SIZE-1:0] buf_addr_i,
  input  logic [Z_SIZE-1:0]    buf_data_w_i,
  output logic [Z_SIZE-1:0]    buf_data_r_o,
  input  logic                 data_r_ready_i,
  output logic                 data_r_valid_o,
  input  logic                 data_w_valid_i,
  output logic                 data_w_ready_o,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  typedef enum logic [2:0] {IDLE, CLEAR, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK} state_t;

  state_t              state;
  logic [3:0]          lat_cnt;
  logic [IDX_W-1:0]    clr_idx;
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_ok;
  logic [Z_SIZE-1:0]   cur_wdata;

  logic [Z_SIZE-1:0]   mem [DEPTH];

  // Request decode: offset from the base, range-checked at full address width
  logic [ADDR_SIZE-1:0] req_off;
  logic                 req_ok;
  logic [IDX_W-1:0]     req_idx;

  assign req_off = buf_addr_i - BASE_ADDR;
  assign req_ok  = (buf_addr_i >= BASE_ADDR) && (req_off < ADDR_SIZE'(DEPTH));
  assign req_idx = req_off[IDX_W-1:0];

  // Response word: live request while idle (zero-latency read), captured request otherwise
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ok;
  logic [Z_SIZE-1:0] rd_word;

  assign rd_idx  = (state == IDLE) ? req_idx : cur_idx;
  assign rd_ok   = (state == IDLE) ? req_ok  : cur_ok;
  assign rd_word = rd_ok ? mem[rd_idx] : '1;

  // Storage write port: clear engine or accepted in-range write handshake
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [Z_SIZE-1:0] mem_wdata;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = '1;
    if (!rst_i) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (state == WR_ACK && data_w_valid_i && cur_ok) begin
        mem_we    = 1'b1;
        mem_waddr = cur_idx;
        mem_wdata = cur_wdata;
      end
    end
  end

  // Depth storage array
  // NOTE: storage has no reset; contents survive rst_i and a clear is an explicit operation, which keeps this a plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered handshake, busy and error outputs
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst_i) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      clr_idx        <= '0;
      data_r_valid_o <= 1'b0;
      data_w_ready_o <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
      buf_data_r_o   <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_o  <= 1'b1;
          end else if ((buf_r_w_i && data_r_ready_i) || (!buf_r_w_i && data_w_valid_i)) begin
            cur_idx   <= req_idx;
            cur_ok    <= req_ok;
            cur_wdata <= buf_data_w_i;
            err_o     <= !req_ok;
            busy_o    <= 1'b1;
            if (buf_r_w_i) begin
              lat_cnt <= RD_LAT;
              if (RD_LAT == 4'd0) begin
                state          <= RD_RESP;
                data_r_valid_o <= 1'b1;
                buf_data_r_o   <= rd_word;
              end else begin
                state <= RD_WAIT;
              end
            end else begin
              lat_cnt <= WR_LAT;
              if (WR_LAT == 4'd0) begin
                state          <= WR_ACK;
                data_w_ready_o <= 1'b1;
              end else begin
                state <= WR_WAIT;
              end
            end
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state          <= RD_RESP;
            data_r_valid_o <= 1'b1;
            buf_data_r_o   <= rd_word;
          end
        end
        RD_RESP: begin
          if (data_r_ready_i) begin
            state          <= IDLE;
            data_r_valid_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        WR_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state          <= WR_ACK;
            data_w_ready_o <= 1'b1;
          end
        end
        WR_ACK: begin
          if (data_w_valid_i) begin
            state          <= IDLE;
            data_w_ready_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          data_r_valid_o <= 1'b0;
          data_w_ready_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/z_buffer_mem_responder.md
Name: z_buffer_mem_responder

Overview:
- Memory-side responder for the depth-buffer request interface driven by the rasteriser's z-buffer unit.
- Holds X_RES*Y_RES depth words of Z_SIZE bits at a fixed base address.
- Answers single-beat reads and writes through the valid/ready handshakes, with programmable response latency.
- Provides a self-clear engine that fills storage with maximum depth (all ones); it is used as the on-chip depth store and as a bench model for the z-buffer unit.

Parameters:
- Z_SIZE, 8, depth word width.
- X_RES, 4, horizontal pixels.
- Y_RES, 4, vertical pixels.
- DEPTH, X_RES*Y_RES, number of stored words.
- ADDR_SIZE, 32, request address width.
- BASE_ADDR, 0, address of word 0.
- READ_LATENCY, 1, extra wait cycles before read data is presented (0..15).
- WRITE_LATENCY, 0, extra wait cycles before write acknowledge (0..15).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- buf_r_w_i  in  1  request direction: 1 = read, 0 = write.
- buf_addr_i  in  ADDR_SIZE  request address.
- buf_data_w_i  in  Z_SIZE  write data.
- buf_data_r_o  out  Z_SIZE  read data; meaningful only while data_r_valid_o is high.
- data_r_ready_i  in  1  initiator read request and response acceptance.
- data_r_valid_o  out  1  read data valid.
- data_w_valid_i  in  1  initiator write request.
- data_w_ready_o  out  1  write acknowledge.
- clear_i  in  1  start a clear of all words to all ones.
- busy_o  out  1  responder is not in IDLE.
- err_o  out  1  one-cycle pulse when an out-of-range request is accepted.

Behaviour:
- Reset:
  - State goes to IDLE; data_r_valid_o, data_w_ready_o, busy_o and err_o go to 0; buf_data_r_o goes to 0; latency counter goes to 0.
  - Storage is not reset.
  - Reset mid-transaction or mid-clear aborts it; no further storage write occurs.
- States: IDLE, CLEAR, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK.
- Acceptance in IDLE, evaluated per edge in priority order:
  - clear_i -> CLEAR.
  - else buf_r_w_i && data_r_ready_i -> read accepted.
  - else !buf_r_w_i && data_w_valid_i -> write accepted.
  - On any acceptance, capture address and write data.
- Index computation:
  - index = buf_addr_i - BASE_ADDR, computed at ADDR_SIZE width.
  - The request is in range iff BASE_ADDR <= buf_addr_i and index < DEPTH (unsigned compare).
- Read path:
  - At accept edge E0: counter loaded with READ_LATENCY; go to RD_WAIT (straight to RD_RESP if READ_LATENCY = 0).
  - RD_WAIT decrements the counter each cycle and leaves for RD_RESP when it reaches 0.
  - Entering RD_RESP registers data_r_valid_o = 1 and buf_data_r_o = mem[index], or all ones if out of range.
  - data_r_valid_o rises exactly 1+READ_LATENCY cycles after E0.
  - data_r_valid_o and buf_data_r_o are held stable until an edge with data_r_valid_o && data_r_ready_i; at that edge valid drops and the state returns to IDLE.
  - Storage is read at the transition into RD_RESP, so a write cannot intervene (single outstanding request).
- Write path:
  - At accept edge E0: counter loaded with WRITE_LATENCY; go to WR_WAIT (or WR_ACK if 0).
  - Entering WR_ACK registers data_w_ready_o = 1, exactly 1+WRITE_LATENCY cycles after E0.
  - In WR_ACK, on an edge with data_w_valid_i high: mem[index] is written with the captured data (in range only); data_w_ready_o drops; the state returns to IDLE.
  - If data_w_valid_i is low in WR_ACK, ready is held and no write occurs.
- Out-of-range requests:
  - err_o pulses for exactly one cycle, the cycle after accept.
  - The handshake still completes normally so the initiator never hangs.
  - Writes are dropped; reads return all ones.
- Clear:
  - CLEAR writes all ones to words 0..DEPTH-1, one word per cycle, in DEPTH cycles, then returns to IDLE.
  - Requests are ignored while clearing; valid and ready outputs stay 0.
  - clear_i asserted again during CLEAR has no effect.
- Only one outstanding transaction exists. Request inputs are ignored outside IDLE except for the handshake signals in RD_RESP and WR_ACK.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- Reset, then clear_i for 1 cycle -> busy_o high for 16 cycles (4x4); afterwards, reading every address 0..15 returns 0xFF.
- READ_LATENCY=1, read addr 5 after writing 0x3C there -> data_r_valid_o rises 2 cycles after accept with 0x3C; it holds while data_r_ready_i is low for 3 cycles and drops on the handshake edge.
- WRITE_LATENCY=2, write 0x10 to addr 15 -> data_w_ready_o rises 3 cycles after accept; a read of addr 15 returns 0x10; addr 14 remains 0xFF.
- Request at address BASE_ADDR+16 (read) and BASE_ADDR-1 (write) -> err_o pulses once each; the read returns 0xFF; storage is unchanged; both handshakes complete.
- Connect to the z-buffer unit with depth func LESS, store 0x80, draw z=0x40 then z=0x90 -> first passes and the stored value becomes 0x40; second fails and the value stays 0x40.
- Assert rst_i in RD_WAIT and in the middle of CLEAR (word 7) -> outputs go to reset values next cycle; in the CLEAR case words 7..15 keep their old contents.
